uart_tx_byte_sched: RTL and testbench
=====================================

# uart_tx_byte_sched

Byte scheduler between the AXI4-Lite slave register file and the UART transmitter. It accepts 32-bit words with byte strobes from the register write path and buffers them in a small word FIFO. It then feeds the enabled bytes, LSB first, one at a time into the UART TX core using its start/busy/done handshake. The register file can therefore post writes at bus speed while transmission proceeds at baud rate.

## Interface
- FIFO_DEPTH, 4, word FIFO depth (power of two, ≥2)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- wr_valid  input  1  register file presents a word
- wr_ready  output  1  FIFO can accept a word
- wr_data  input  32  word to transmit
- wr_strb  input  4  byte enables; bit i selects wr_data[8i+7:8i]
- tx_start  output  1  one-cycle start pulse to UART TX
- tx_byte  output  8  byte to send; valid while tx_start=1
- tx_busy  input  1  UART TX is shifting a frame
- tx_done  input  1  one-cycle pulse at end of stop bit
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words buffered
- sched_busy  output  1  FSM not IDLE or FIFO not empty

## Operation
- Push on wr_valid && wr_ready; wr_ready = (fifo_count != FIFO_DEPTH). A push is never accepted while full, even if a pop occurs in the same cycle.
- FSM states: IDLE, LOAD, SEND, WAIT_DONE.
- IDLE: if FIFO is not empty, pop into the cur_data/cur_strb holding registers and go to LOAD. Otherwise stay.
- LOAD: if cur_strb==0, discard the word (no tx_start) and go to IDLE. Otherwise go to SEND.
- SEND: sel = index of lowest set bit of cur_strb.
  - If tx_busy==0: assert tx_start, drive tx_byte = cur_data[8·sel+:8], clear cur_strb[sel], go to WAIT_DONE.
  - If tx_busy==1: hold in SEND with tx_start low.
- WAIT_DONE: on tx_done, go to SEND if cur_strb != 0, else go to IDLE. tx_done seen in any other state is ignored.
- Byte order is strictly ascending lane index; disabled lanes are skipped without a gap cycle.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
- Reset, asynchronous, at any point including mid-word:
  - FSM goes to IDLE; FIFO is emptied; cur_strb=0.
  - All outputs go to 0 except wr_ready, which goes to 1 as soon as reset is released.
  - A UART frame already in flight is not aborted. The next tx_start waits for tx_busy==0.

## Timing
- Reset values: wr_ready=0 while reset is asserted; tx_start=0, tx_byte=0, fifo_count=0, sched_busy=0.
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - pop at edge N+1;
  - LOAD during cycle N+1..N+2;
  - tx_start high in cycle N+2..N+3 if tx_busy=0.
- tx_start is high for exactly one cycle per byte and is registered. tx_byte is registered and held until the next tx_start.
- Between bytes of one word: tx_done at edge M puts the FSM in SEND, and tx_start is high in cycle M+1 if tx_busy=0.
- An all-zero-strobe word occupies 2 cycles (IDLE pop, LOAD) and produces no output.
- sched_busy is combinational from state and fifo_count.

## Structure
- Package uart_sched_pkg holds:
  - enum sched_state_t {IDLE, LOAD, SEND, WAIT_DONE};
  - BYTES_PER_WORD=4;
  - function lowest_set(logic [3:0]) returning a 2-bit index.
- Sub-module sched_word_fifo: synchronous FIFO, 36-bit entries (strb & data), parameter DEPTH, with push, pop, full, empty and count ports.
- Top-level contents: FSM, holding registers and output registers.

## Test plan
- Write 0xabcdeffc with strb 1111, UART model with tx_busy for 100 cycles per byte → tx_start ×4 with tx_byte 0xfc, 0xef, 0xcd, 0xab in that order; sched_busy drops after the 4th tx_done.
- Write 0x00560078 with strb 0101 → exactly two starts, 0x78 then 0x56; no start for lanes 1 or 3.
- Write any data with strb 0000 → no tx_start; fifo_count goes 1→0 within 2 cycles; sched_busy returns to 0.
- Hold tx_done low and post 5 words back-to-back → fifo_count reaches 4 and wr_ready=0 on the 5th attempt. That word is accepted one cycle after the next pop; no word is lost or duplicated.
- Force tx_busy=1 while in SEND → tx_start stays low until tx_busy falls, then pulses exactly once.
- Assert rst_n after the 2nd byte of a 4-byte word → all outputs reach reset values immediately. A new word 0x11223344/1000 after release sends only 0x11, with no residue from the old word.

Source files
------------

// File: rtl/uart_tx_byte_sched_pkg.sv
// Shared types and helpers for the UART TX byte scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      SEND      = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int ENTRY_W        = BYTES_PER_WORD * 9;   // strobes + data

   function automatic logic [1:0] lowest_set(input logic [3:0] strb);
      if (strb[0])      return 2'd0;
      else if (strb[1]) return 2'd1;
      else if (strb[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage

// File: rtl/uart_tx_byte_sched_if.sv
// Register-write and UART-TX handshake bundle of the byte scheduler.
interface uart_tx_byte_sched_if #(
   parameter int FIFO_DEPTH = 4
);
   import uart_sched_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                          wr_valid;
   logic                          wr_ready;
   logic [8*BYTES_PER_WORD-1:0]   wr_data;
   logic [BYTES_PER_WORD-1:0]     wr_strb;
   logic                          tx_start;
   logic [7:0]                    tx_byte;
   logic                          tx_busy;
   logic                          tx_done;
   logic [CW-1:0]                 fifo_count;
   logic                          sched_busy;

   modport master (
      output wr_valid, wr_data, wr_strb, tx_busy, tx_done,
      input  wr_ready, tx_start, tx_byte, fifo_count, sched_busy
   );

   modport slave (
      input  wr_valid, wr_data, wr_strb, tx_busy, tx_done,
      output wr_ready, tx_start, tx_byte, fifo_count, sched_busy
   );

endinterface

// File: rtl/uart_tx_byte_sched_fifo.sv
// Show-ahead synchronous word FIFO holding {strb, data} entries.
module sched_word_fifo
   import uart_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage is not reset; count and pointers alone say which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_byte_sched.sv
// Splits buffered 32-bit strobed words into LSB-first bytes for the UART TX core.
module uart_tx_byte_sched
   import uart_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_tx_byte_sched_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LOAD = LOAD;
   localparam logic [1:0] S_SEND = SEND;
   localparam logic [1:0] S_WAIT = WAIT_DONE;

   logic [1:0]            state;
   logic [1:0]            state_d;
   logic [31:0]           cur_data;
   logic [3:0]            cur_strb;
   logic [1:0]            sel;
   logic                  tx_start_q;
   logic                  start_d;
   logic [7:0]            tx_byte_q;

   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ENTRY_W-1:0]    fifo_rdata;
   logic [CW-1:0]         count;

   assign push = bus.wr_valid && bus.wr_ready;
   assign pop  = (state == S_IDLE) && !fifo_empty;

   sched_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.wr_strb, bus.wr_data}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign bus.wr_ready   = !rst_n && !fifo_full;
   assign bus.fifo_count = count;
   assign bus.sched_busy = (state != S_IDLE) || (count != '0);
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_byte    = tx_byte_q;

   assign sel = lowest_set(cur_strb);

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
         S_LOAD:  state_d = (cur_strb == 4'b0000) ? S_IDLE : S_SEND;
         S_SEND:  if (tx_start_q) state_d = S_WAIT;
         S_WAIT:  if (bus.tx_done) state_d = (cur_strb != 4'b0000) ? S_SEND : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The start pulse is registered one edge ahead, so it is high during the SEND cycle itself.
   assign start_d = (state_d == S_SEND) && !bus.tx_busy;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= S_IDLE;
         cur_data   <= '0;
         cur_strb   <= '0;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
      end else begin
         state      <= state_d;
         tx_start_q <= start_d;
         if (start_d) tx_byte_q <= cur_data[{sel, 3'b000} +: 8];
         if (pop) begin
            cur_data <= fifo_rdata[31:0];
            cur_strb <= fifo_rdata[ENTRY_W-1:32];
         end
         if (state == S_SEND && tx_start_q) cur_strb[sel] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_byte_sched.sv
// Directed bench for uart_tx_byte_sched with a simple UART TX busy/done model.
module tb_uart_tx_byte_sched;
   import uart_sched_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_byte_sched_if #(.FIFO_DEPTH(DEPTH)) bus();

   uart_tx_byte_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // UART model: busy for busy_len cycles after a start, then a one-cycle done pulse.
   int   busy_len  = 100;
   logic hold_done = 1'b0;
   logic force_busy = 1'b0;
   int   busy_cnt  = 0;
   logic done_q    = 1'b0;

   assign bus.tx_busy = (busy_cnt != 0) || force_busy;
   assign bus.tx_done = done_q;

   always @(posedge clk) begin
      done_q <= 1'b0;
      if (busy_cnt != 0) begin
         if (!(hold_done && busy_cnt == 1)) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) done_q <= 1'b1;
         end
      end else if (bus.tx_start) begin
         busy_cnt <= busy_len;
      end
   end

   // Monitor: edge counter, sent-byte log, done count, pop edges, overlapping starts.
   int         cyc = 0;
   logic [7:0] log_q[$];
   int         log_cyc[$];
   int         done_seen = 0;
   int         pop_cyc = -1;
   int         overlap = 0;
   logic [2:0] cnt_prev = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.tx_start) begin
         log_q.push_back(bus.tx_byte);
         log_cyc.push_back(cyc);
         if (busy_cnt != 0) overlap <= overlap + 1;
      end
      if (bus.tx_done) done_seen <= done_seen + 1;
      if (bus.fifo_count < cnt_prev) pop_cyc <= cyc - 1;
      cnt_prev <= bus.fifo_count;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_word(input logic [31:0] d, input logic [3:0] s, input int budget,
                            output int acc);
      int w = 0;
      acc = -1;
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      bus.wr_strb  = s;
      while (!bus.wr_ready && w < budget) begin
         @(negedge clk);
         w++;
      end
      check("push_ready", {31'd0, bus.wr_ready}, 32'd1);
      if (bus.wr_ready) begin
         @(posedge clk);
         #1;
         acc = cyc - 1;
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_sched_idle(input int budget, input string name);
      int w = 0;
      @(negedge clk);
      while (bus.sched_busy && w < budget) begin
         @(negedge clk);
         w++;
      end
      check({name, "_idle"}, {31'd0, bus.sched_busy}, 32'd0);
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int w = 0;
      while (log_q.size() < n && w < budget) begin
         @(negedge clk);
         w++;
      end
      check({name, "_logwait"}, log_q.size(), n);
   endtask

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      int          n;
      logic [7:0]  exp [4];
   } vec_t;

   vec_t vecs [5];

   task automatic set_vec(input int i, input logic [31:0] d, input logic [3:0] s, input int n,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
      vecs[i].data   = d;
      vecs[i].strb   = s;
      vecs[i].n      = n;
      vecs[i].exp[0] = b0;
      vecs[i].exp[1] = b1;
      vecs[i].exp[2] = b2;
      vecs[i].exp[3] = b3;
   endtask

   initial begin
      int base, base_done, acc, rel;
      logic [7:0] exp_full [6];

      set_vec(0, 32'habcdeffc, 4'b1111, 4, 8'hfc, 8'hef, 8'hcd, 8'hab);
      set_vec(1, 32'h00560078, 4'b0101, 2, 8'h78, 8'h56, 8'h00, 8'h00);
      set_vec(2, 32'hdeadbeef, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      set_vec(3, 32'ha1b2c3d4, 4'b0110, 2, 8'hc3, 8'hb2, 8'h00, 8'h00);
      set_vec(4, 32'h5a6b7c8d, 4'b1000, 1, 8'h5a, 8'h00, 8'h00, 8'h00);

      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.wr_strb  = '0;

      // Reset is active-high on rst_n.
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_wr_ready",   {31'd0, bus.wr_ready},   32'd0);
      check("rst_tx_start",   {31'd0, bus.tx_start},   32'd0);
      check("rst_tx_byte",    {24'd0, bus.tx_byte},    32'd0);
      check("rst_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
      check("rst_sched_busy", {31'd0, bus.sched_busy}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rel_wr_ready", {31'd0, bus.wr_ready}, 32'd1);

      // Table-driven words.
      for (int i = 0; i < 5; i++) begin
         base      = log_q.size();
         base_done = done_seen;
         push_word(vecs[i].data, vecs[i].strb, 20, acc);
         wait_sched_idle(1000, $sformatf("v%0d", i));
         check($sformatf("v%0d_dones", i), done_seen - base_done, vecs[i].n);
         check($sformatf("v%0d_nbytes", i), log_q.size() - base, vecs[i].n);
         for (int k = 0; k < vecs[i].n; k++) begin
            if (base + k < log_q.size()) begin
               check($sformatf("v%0d_byte%0d", i, k), {24'd0, log_q[base + k]},
                     {24'd0, vecs[i].exp[k]});
               if (k == 0)
                  check($sformatf("v%0d_first_lat", i), log_cyc[base] - acc, 3);
               else
                  check($sformatf("v%0d_gap%0d", i, k),
                        log_cyc[base + k] - log_cyc[base + k - 1], busy_len + 2);
            end
         end
      end

      // Zero-strobe word: popped next edge, LOAD one cycle, then idle.
      base = log_q.size();
      push_word(32'h12345678, 4'b0000, 20, acc);
      check("z_count_push", {29'd0, bus.fifo_count}, 32'd1);
      @(posedge clk); #1;
      check("z_count_pop", {29'd0, bus.fifo_count}, 32'd0);
      check("z_busy_load", {31'd0, bus.sched_busy}, 32'd1);
      @(posedge clk); #1;
      check("z_busy_done", {31'd0, bus.sched_busy}, 32'd0);
      check("z_no_start",  log_q.size() - base, 0);

      // tx_busy held high while in SEND.
      busy_len   = 10;
      force_busy = 1'b1;
      base = log_q.size();
      push_word(32'h00000042, 4'b0001, 20, acc);
      repeat (20) @(negedge clk);
      check("fb_held_nostart", log_q.size() - base, 0);
      check("fb_held_busy", {31'd0, bus.sched_busy}, 32'd1);
      rel = cyc;
      force_busy = 1'b0;
      wait_sched_idle(200, "fb");
      check("fb_one_start", log_q.size() - base, 1);
      if (log_q.size() > base) begin
         check("fb_byte", {24'd0, log_q[base]}, 32'h42);
         check("fb_start_edge", log_cyc[base], rel + 1);
      end

      // FIFO full with tx_done withheld.
      busy_len  = 3;
      hold_done = 1'b1;
      base = log_q.size();
      push_word(32'h000000a0, 4'b0001, 20, acc);
      wait_log(base + 1, 50, "full_stall");
      repeat (8) @(negedge clk);
      check("full_stall_count", {29'd0, bus.fifo_count}, 32'd0);
      for (int k = 1; k <= 4; k++) push_word(32'h000000a0 + k, 4'b0001, 20, acc);
      check("full_count4", {29'd0, bus.fifo_count}, 32'd4);
      check("full_not_ready", {31'd0, bus.wr_ready}, 32'd0);
      fork
         push_word(32'h000000a5, 4'b0001, 50, acc);
         begin
            repeat (2) @(negedge clk);
            check("full_blocked_count", {29'd0, bus.fifo_count}, 32'd4);
            check("full_blocked_ready", {31'd0, bus.wr_ready}, 32'd0);
            hold_done = 1'b0;
         end
      join
      check("full_accept_after_pop", acc - pop_cyc, 1);
      wait_sched_idle(300, "full");
      check("full_nbytes", log_q.size() - base, 6);
      for (int k = 0; k < 6; k++) exp_full[k] = 8'ha0 + 8'(k);
      for (int k = 0; k < 6; k++)
         if (base + k < log_q.size())
            check($sformatf("full_byte%0d", k), {24'd0, log_q[base + k]}, {24'd0, exp_full[k]});

      // Reset after the second byte of a four-byte word.
      busy_len = 20;
      base = log_q.size();
      push_word(32'h87654321, 4'b1111, 20, acc);
      wait_log(base + 2, 200, "mr");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mr_tx_start",   {31'd0, bus.tx_start},   32'd0);
      check("mr_tx_byte",    {24'd0, bus.tx_byte},    32'd0);
      check("mr_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
      check("mr_sched_busy", {31'd0, bus.sched_busy}, 32'd0);
      check("mr_wr_ready",   {31'd0, bus.wr_ready},   32'd0);
      check("mr_sent_before", log_q.size() - base, 2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_rel_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      base = log_q.size();
      push_word(32'h11223344, 4'b1000, 20, acc);
      wait_sched_idle(300, "mr_new");
      check("mr_new_nbytes", log_q.size() - base, 1);
      if (log_q.size() > base) check("mr_new_byte", {24'd0, log_q[base]}, 32'h11);

      check("no_start_while_busy", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
